// File: rtl/clk_div_multi_if.sv
// rtl/clk_div_multi_if.sv - shared divisor configuration port for clk_div_multi
interface clk_div_multi_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 32
);
    logic             cfg_wr;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;

    modport master (output cfg_wr, output cfg_ch, output cfg_div);
    modport slave  (input  cfg_wr, input  cfg_ch, input  cfg_div);
endinterface

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel runtime-programmable clock divider
// Divisor changes are staged in a shadow register and applied only at a period boundary.
module clk_div_multi #(
    parameter int          NUM_CH      = 4,
    parameter int          CH_W        = 2,
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    clk_div_multi_if.slave    cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] active_div;
        logic [CNT_W-1:0] shadow_div;
        logic             pend;
        logic             level;
        logic             strobe;
        logic             stopped;
        logic             last;
        logic             wr_hit;
        logic             apply;
        logic [CNT_W:0]   half;

        always_comb begin
            stopped = (active_div == '0);
            // D-1 is only formed when D>=1, so no wrap at D=0
            last    = !stopped && (cnt == active_div - CNT_W'(1));
            half    = ({1'b0, active_div} + (CNT_W+1)'(1)) >> 1;
            wr_hit  = cfg.cfg_wr && (cfg.cfg_ch == CH_W'(g));
            apply   = pend && (!en[g] || stopped || last);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt        <= '0;
                active_div <= RESET_DIV;
                shadow_div <= RESET_DIV;
                pend       <= 1'b0;
                level      <= 1'b0;
                strobe     <= 1'b0;
            end else begin
                if (apply) begin
                    active_div <= shadow_div;
                    cnt        <= '0;
                    pend       <= 1'b0;
                end else if (!en[g] || stopped || last) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                // a write on the apply edge lands after the old shadow was consumed
                if (wr_hit) begin
                    shadow_div <= cfg.cfg_div;
                    pend       <= 1'b1;
                end
                level  <= en[g] && !stopped && ({1'b0, cnt} < half);
                strobe <= en[g] && last;
            end
        end

        assign clk_out[g] = level;
        assign tick[g]    = strobe;
        assign pending[g] = pend;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, multi-channel successor to the single fixed-ratio slow-clock divider.
- Each of NUM_CH channels divides the system clock by a runtime-programmable divisor.
- Each channel outputs a near-50% duty level (clk_out) and a one-cycle period-end strobe (tick).
- New divisors are written through a shared config port and take effect glitch-free at the next period boundary; sits between the board clock and slow-rate consumers (display refresh, stepping of the multiplier datapath, LED blink).

Parameters:
NUM_CH, 4, number of independent divider channels
CH_W, 2, width of cfg_ch; 2**CH_W >= NUM_CH
CNT_W, 32, width of divisor and per-channel counter
DEFAULT_DIV, 100_000_000, divisor loaded into every channel at reset (1 Hz from 100 MHz)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
en  in  NUM_CH  per-channel run enable
cfg_wr  in  1  config write strobe, one cycle per write
cfg_ch  in  CH_W  channel index for cfg_wr
cfg_div  in  CNT_W  new divisor for channel cfg_ch
clk_out  out  NUM_CH  divided clock level per channel (registered)
tick  out  NUM_CH  one-cycle pulse at the end of each period (registered)
pending  out  NUM_CH  1 = divisor written but not yet applied

Behaviour:
- Per-channel state: cnt[CNT_W], active_div[CNT_W], shadow_div[CNT_W], pending. All channels are independent and identical.
- Reset (rst_n low, async): cnt=0, active_div=shadow_div=DEFAULT_DIV, pending=0, clk_out=0, tick=0. Reset mid-period discards the period and any pending write.
- Let D=active_div and H=(D+1)>>1, so the high phase is ceil(D/2) cycles.
- Run (en=1, D>=1): each clk, cnt <= (cnt==D-1) ? 0 : cnt+1.
  - clk_out <= (cnt < H).
  - tick <= (cnt==D-1).
  - Outputs reflect the previous cycle's cnt, giving one cycle of latency.
- Period: exactly D clocks.
  - D=1: clk_out constant 1, tick every cycle.
  - D=2: 1 high / 1 low.
  - D=3: 2 high / 1 low.
- Stopped (active_div==0): cnt held 0, clk_out=0, tick=0.
- Disabled (en=0): cnt <= 0, clk_out <= 0, tick <= 0. Re-asserting en starts a fresh period with cnt=0, so first clk_out high appears one cycle later.
- Config write: cfg_wr=1 with cfg_ch<NUM_CH sets shadow_div <= cfg_div and pending <= 1 next cycle. cfg_ch>=NUM_CH is ignored. Consecutive writes to a pending channel: last write wins.
- Apply rule: active_div <= shadow_div, cnt <= 0, pending <= 0 when pending=1 and any of the following holds:
  - en=1 and cnt==D-1 (period boundary), or
  - en=0, or
  - active_div==0.
- Applying at the boundary means no truncated or stretched period ever appears on clk_out.
- Simultaneous cfg_wr and apply on the same channel: the apply uses the shadow value held before the edge. The new write lands in shadow_div, pending stays 1, and the new value applies at the following boundary.
- Writing cfg_div=0 stops the channel at the next boundary; clk_out ends low.
- No arithmetic overflow: cnt never exceeds D-1, and D-1 is evaluated only when D>=1.

Test Plan:
- Bench override NUM_CH=2, CNT_W=8, DEFAULT_DIV=4. After reset release with en=2'b01: ch0 clk_out repeats 1,1,0,0, starting the second cycle after en=1; tick pulses one cycle every 4 clocks aligned with the final low cycle; ch1 stays 0.
- Odd and unit divisors: write ch0 div=3 -> after current period completes, clk_out pattern is 1,1,0 with period 3. Write div=1 -> clk_out constant 1, tick high every cycle.
- Mid-period write: write ch0 div=6 when cnt=1 of a div=4 period -> pending=1; the current 4-cycle period completes unchanged; pending drops at the boundary; the next period is 3 high / 3 low.
- Write collides with boundary: write div=5 on the cycle cnt==D-1 while the shadow holds 6 -> next period is 6; pending stays 1; the period after is 5 (3 high, 2 low).
- Stop and disable: write div=0 -> channel stops at the boundary, clk_out=0, tick=0. Write div=2 to the stopped channel -> toggles 1,0 within 2 cycles. Deassert en mid-high -> clk_out 0 next cycle; reassert -> fresh period from cnt=0.
- Async reset mid-operation: pull rst_n low between edges with ch0 div=6 and pending=1 -> clk_out, tick and pending go 0 immediately. After release, the channel runs at DEFAULT_DIV=4. cfg_ch=3 (out of range) writes change nothing.
